// File: rtl/fifo_unpack_pkg.sv
// rtl/fifo_unpack_pkg.sv - shared sizes, types and helpers for the 32-to-4 unpacking FIFO
// Purpose: storage geometry (nibble depth, word width), pointer/address types and the
//          write-count normalisation used by every file of the unpacking FIFO.
// Ports:   none (package).
package fifo_unpack_pkg;

  localparam int DEPTH    = 32;               // storage in nibbles
  localparam int WR_W     = 32;               // write word width
  localparam int RD_W     = 4;                // read width, one nibble
  localparam int WORD_NIB = WR_W / RD_W;      // nibbles per write word
  localparam int PTR_W    = $clog2(DEPTH) + 1; // extra MSB is the wrap bit
  localparam int ADDR_W   = PTR_W - 1;
  localparam int CNT_W    = 4;

  typedef logic [RD_W-1:0]   nib_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // A count of 0 means a full word; counts beyond a word are clamped to a full word.
  function automatic cnt_t eff_cnt(input cnt_t cnt);
    if (cnt == '0 || cnt > cnt_t'(WORD_NIB)) begin
      return cnt_t'(WORD_NIB);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fifo_unpack_32to4_if.sv
// rtl/fifo_unpack_32to4_if.sv - write/read/status bundle of the 32-to-4 unpacking FIFO
// Purpose: groups the word write port, the nibble read port, drop and status outputs.
// Ports:   master = producer/consumer side (drives wr_*, rd_valid_i, drop_i)
//          slave  = FIFO side (drives wr_ready_o, rd_*_o, empty_o, full_o, level_o, err_o)
interface fifo_unpack_32to4_if;
  import fifo_unpack_pkg::*;

  logic            wr_valid_i;
  logic [WR_W-1:0] wr_data_i;
  cnt_t            wr_cnt_i;
  logic            wr_last_i;
  logic            wr_ready_o;
  logic            rd_valid_i;
  nib_t            rd_data_o;
  logic            rd_last_o;
  logic            rd_avail_o;
  logic            drop_i;
  logic            empty_o;
  logic            full_o;
  ptr_t            level_o;
  logic            err_o;

  modport master (
    output wr_valid_i, wr_data_i, wr_cnt_i, wr_last_i, rd_valid_i, drop_i,
    input  wr_ready_o, rd_data_o, rd_last_o, rd_avail_o, empty_o, full_o, level_o, err_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i, wr_cnt_i, wr_last_i, rd_valid_i, drop_i,
    output wr_ready_o, rd_data_o, rd_last_o, rd_avail_o, empty_o, full_o, level_o, err_o
  );

endinterface

// File: rtl/fifo_unpack_mem.sv
// rtl/fifo_unpack_mem.sv - nibble+tag register file with a word-wide masked write port
// Purpose: DEPTH x 5-bit storage ({tag, nibble}). One write writes up to WORD_NIB
//          consecutive entries starting at waddr_i (wrapping at DEPTH); one async read.
// Ports:   clk                clock
//          we_i               write enable
//          waddr_i, wcnt_i    base address and lane count (1..WORD_NIB)
//          wdata_i, wlast_i   word data (lane 0 = [3:0]) and packet-end flag
//          raddr_i            read address
//          rdata_o, rlast_o   stored nibble and tag at raddr_i
module fifo_unpack_mem
  import fifo_unpack_pkg::*;
(
  input  logic            clk,
  input  logic            we_i,
  input  addr_t           waddr_i,
  input  cnt_t            wcnt_i,
  input  logic [WR_W-1:0] wdata_i,
  input  logic            wlast_i,
  input  addr_t           raddr_i,
  output nib_t            rdata_o,
  output logic            rlast_o
);

  logic [DEPTH-1:0][RD_W:0] mem_q;
  logic [DEPTH-1:0][RD_W:0] mem_d;

  // Lane i lands at base+i; the addr_t-wide sum wraps a straddling word to index 0.
  // Only the last valid lane carries the packet-end tag.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      for (int i = 0; i < WORD_NIB; i++) begin
        if (cnt_t'(i) < wcnt_i) begin
          mem_d[waddr_i + addr_t'(i)] = {wlast_i && (cnt_t'(i) == wcnt_i - cnt_t'(1)),
                                         wdata_i[i*RD_W +: RD_W]};
        end
      end
    end
  end

  // Contents need no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign {rlast_o, rdata_o} = mem_q[raddr_i];

endmodule

// File: rtl/fifo_unpack_32to4.sv
// rtl/fifo_unpack_32to4.sv - 32-bit word in, 4-bit nibble out downsizing FIFO with packet tags
// Purpose: stores up to 32 nibbles; each accepted word contributes 1..8 nibbles, the last
//          of which carries wr_last_i. Nibbles are read one at a time, lowest nibble first.
//          drop_i discards everything stored plus any same-cycle write.
// Ports:   clk, rst (async, active-low)
//          bus (slave): wr_valid_i/wr_data_i/wr_cnt_i/wr_last_i/wr_ready_o,
//                       rd_valid_i/rd_data_o/rd_last_o/rd_avail_o, drop_i,
//                       empty_o, full_o, level_o, err_o
// Macro:   FIFO_UNPACK_ERR_CHK_EN - builds the sticky protocol-error flag; otherwise err_o=0.
module fifo_unpack_32to4
  import fifo_unpack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fifo_unpack_32to4_if.slave bus
);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t level;
  logic empty;
  logic full;
  logic wr_ready;
  logic wr_acc;
  logic rd_pop;
  cnt_t wr_cnt_eff;
  nib_t mem_rdata;
  logic mem_rlast;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                    (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
  // A full word must always fit, so accept only with at least WORD_NIB free slots.
  assign wr_ready = (level <= ptr_t'(DEPTH - WORD_NIB));
  assign wr_acc   = bus.wr_valid_i && wr_ready;
  assign rd_pop   = bus.rd_valid_i && !empty;
  assign wr_cnt_eff = eff_cnt(bus.wr_cnt_i);

  // Drop moves the read pointer to the post-write position, which also
  // discards a word accepted in the same cycle and overrides any pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(wr_cnt_eff);
    end
    rd_ptr_d = rd_ptr_q;
    if (bus.drop_i) begin
      rd_ptr_d = wr_ptr_d;
    end else if (rd_pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_unpack_mem u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wcnt_i  (wr_cnt_eff),
    .wdata_i (bus.wr_data_i),
    .wlast_i (bus.wr_last_i),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata),
    .rlast_o (mem_rlast)
  );

  // Stale storage is masked so an empty FIFO always presents zeros.
  assign bus.rd_data_o  = empty ? '0 : mem_rdata;
  assign bus.rd_last_o  = !empty && mem_rlast;
  assign bus.rd_avail_o = !empty;
  assign bus.wr_ready_o = wr_ready;
  assign bus.empty_o    = empty;
  assign bus.full_o     = full;
  assign bus.level_o    = level;

`ifdef FIFO_UNPACK_ERR_CHK_EN
  logic err_q, err_d;

  // Sticky until reset; drop_i deliberately leaves it alone.
  always_comb begin
    err_d = err_q || (bus.rd_valid_i && empty) || (bus.wr_valid_i && !wr_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_unpack_32to4.sv
// tb/tb_fifo_unpack_32to4.sv - self-checking bench for the 32-to-4 unpacking FIFO
module tb_fifo_unpack_32to4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_unpack_32to4_if bus ();

  fifo_unpack_32to4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a queue of {tag, nibble} in read order, plus the sticky error.
  logic [4:0] mq[$];
  logic       m_err;

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic [3:0]  wc;
    logic        wl;
    logic        rv;
    logic        dr;
    logic [3:0]  e_data;
    logic        e_last;
    logic [5:0]  e_level;
    logic        e_empty;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic wv, logic [31:0] wd, logic [3:0] wc, logic wl, logic rv,
                              logic dr, logic [3:0] e_data, logic e_last, logic [5:0] e_level,
                              logic e_empty);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wc = wc; v.wl = wl; v.rv = rv; v.dr = dr;
    v.e_data = e_data; v.e_last = e_last; v.e_level = e_level; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] wd, input logic [3:0] wc,
                       input logic wl, input logic rv, input logic dr);
    bus.wr_valid_i = wv;
    bus.wr_data_i  = wd;
    bus.wr_cnt_i   = wc;
    bus.wr_last_i  = wl;
    bus.rd_valid_i = rv;
    bus.drop_i     = dr;
  endtask

  task automatic model_check(input string tag);
    int         lvl;
    logic [3:0] e_data;
    logic       e_last;
    logic       e_err;
    lvl    = mq.size();
    e_data = (lvl == 0) ? 4'h0 : mq[0][3:0];
    e_last = (lvl == 0) ? 1'b0 : mq[0][4];
`ifdef FIFO_UNPACK_ERR_CHK_EN
    e_err = m_err;
`else
    e_err = 1'b0;
`endif
    chk({tag, ".rd_data"},  bus.rd_data_o,  e_data);
    chk({tag, ".rd_last"},  bus.rd_last_o,  e_last);
    chk({tag, ".level"},    bus.level_o,    lvl);
    chk({tag, ".empty"},    bus.empty_o,    lvl == 0);
    chk({tag, ".full"},     bus.full_o,     lvl == 32);
    chk({tag, ".avail"},    bus.rd_avail_o, lvl != 0);
    chk({tag, ".wr_ready"}, bus.wr_ready_o, lvl <= 24);
    chk({tag, ".err"},      bus.err_o,      e_err);
  endtask

  // Applies the FIFO rules to the inputs currently on the bus.
  task automatic model_update();
    int   lvl;
    int   c;
    logic rdy;
    logic emp;
    lvl = mq.size();
    rdy = (lvl <= 24);
    emp = (lvl == 0);
    c   = (bus.wr_cnt_i == 0 || bus.wr_cnt_i > 8) ? 8 : int'(bus.wr_cnt_i);
    if (bus.wr_valid_i && !rdy) m_err = 1'b1;
    if (bus.rd_valid_i && emp)  m_err = 1'b1;
    if (bus.drop_i) begin
      mq.delete();
    end else begin
      if (bus.rd_valid_i && !emp) void'(mq.pop_front());
      if (bus.wr_valid_i && rdy) begin
        for (int i = 0; i < c; i++) begin
          mq.push_back({bus.wr_last_i && (i == c - 1), bus.wr_data_i[i*4 +: 4]});
        end
      end
    end
  endtask

  task automatic step(input string tag);
    model_check(tag);
    model_update();
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cycle(input string tag, input logic wv, input logic [31:0] wd,
                       input logic [3:0] wc, input logic wl, input logic rv, input logic dr);
    drive(wv, wd, wc, wl, rv, dr);
    step(tag);
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_err = 1'b0;
    #1;
    chk("rst.rd_data",  bus.rd_data_o,  0);
    chk("rst.rd_last",  bus.rd_last_o,  0);
    chk("rst.wr_ready", bus.wr_ready_o, 1);
    chk("rst.avail",    bus.rd_avail_o, 0);
    chk("rst.empty",    bus.empty_o,    1);
    chk("rst.full",     bus.full_o,     0);
    chk("rst.level",    bus.level_o,    0);
    chk("rst.err",      bus.err_o,      0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    m_err = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Full word then 8 reads, then a 2-nibble packet.
    tbl[0]  = mk(1, 32'h87654321, 4'd8, 1, 0, 0, 4'h0, 0, 6'd0, 1);
    tbl[1]  = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'h1, 0, 6'd8, 0);
    tbl[2]  = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'h2, 0, 6'd7, 0);
    tbl[3]  = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'h3, 0, 6'd6, 0);
    tbl[4]  = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'h4, 0, 6'd5, 0);
    tbl[5]  = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'h5, 0, 6'd4, 0);
    tbl[6]  = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'h6, 0, 6'd3, 0);
    tbl[7]  = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'h7, 0, 6'd2, 0);
    tbl[8]  = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'h8, 1, 6'd1, 0);
    tbl[9]  = mk(1, 32'h000000AB, 4'd2, 1, 0, 0, 4'h0, 0, 6'd0, 1);
    tbl[10] = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'hB, 0, 6'd2, 0);
    tbl[11] = mk(0, 32'h0, 4'd0, 0, 1, 0, 4'hA, 1, 6'd1, 0);
    tbl[12] = mk(0, 32'h0, 4'd0, 0, 0, 0, 4'h0, 0, 6'd0, 1);

    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].wc, tbl[i].wl, tbl[i].rv, tbl[i].dr);
      chk($sformatf("tbl%0d.rd_data", i), bus.rd_data_o, tbl[i].e_data);
      chk($sformatf("tbl%0d.rd_last", i), bus.rd_last_o, tbl[i].e_last);
      chk($sformatf("tbl%0d.level", i),   bus.level_o,   tbl[i].e_level);
      chk($sformatf("tbl%0d.empty", i),   bus.empty_o,   tbl[i].e_empty);
      step($sformatf("tbl%0d", i));
    end

    // Fill to 32, then read 8 to reopen the write port.
    do_reset();
    for (int i = 0; i < 4; i++) cycle("fill", 1, $urandom, 4'd8, 0, 0, 0);
    chk("fill.level", bus.level_o, 32);
    chk("fill.full", bus.full_o, 1);
    chk("fill.wr_ready", bus.wr_ready_o, 0);
    for (int i = 0; i < 8; i++) cycle("drain", 0, 32'h0, 4'd0, 0, 1, 0);
    chk("drain.wr_ready", bus.wr_ready_o, 1);
    chk("drain.level", bus.level_o, 24);

    // wr_ready boundary at 24/25.
    do_reset();
    for (int i = 0; i < 3; i++) cycle("l24", 1, $urandom, 4'd0, 0, 0, 0);
    chk("l24.wr_ready", bus.wr_ready_o, 1);
    cycle("l25", 1, $urandom, 4'd1, 0, 0, 0);
    chk("l25.level", bus.level_o, 25);
    chk("l25.wr_ready", bus.wr_ready_o, 0);

    // Word straddling index 31 -> 0.
    do_reset();
    cycle("w30", 1, $urandom, 4'd8, 0, 0, 0);
    cycle("w30", 1, $urandom, 4'd8, 0, 0, 0);
    cycle("w30", 1, $urandom, 4'd8, 0, 0, 0);
    cycle("w30", 1, $urandom, 4'd6, 1, 0, 0);
    for (int i = 0; i < 30; i++) cycle("r30", 0, 32'h0, 4'd0, 0, 1, 0);
    cycle("wrap.wr", 1, 32'hFEDCBA98, 4'd8, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap.nib%0d", i), bus.rd_data_o, 8 + i);
      chk($sformatf("wrap.last%0d", i), bus.rd_last_o, i == 7);
      cycle("wrap.rd", 0, 32'h0, 4'd0, 0, 1, 0);
    end
    chk("wrap.empty", bus.empty_o, 1);

    // Concurrent read+write, then drop with a concurrent write.
    do_reset();
    cycle("l5", 1, 32'h54321, 4'd5, 0, 0, 0);
    chk("l5.level", bus.level_o, 5);
    cycle("rw", 1, $urandom, 4'd8, 1, 1'b1, 0);
    chk("rw.level", bus.level_o, 12);
    cycle("drop", 1, $urandom, 4'd4, 0, 1, 1);
    chk("drop.level", bus.level_o, 0);
    chk("drop.empty", bus.empty_o, 1);
    cycle("after_drop", 1, 32'h00000CBA, 4'd3, 1, 0, 0);
    chk("after_drop.level", bus.level_o, 3);
    chk("after_drop.data", bus.rd_data_o, 4'hA);
    for (int i = 0; i < 3; i++) cycle("after_drop.rd", 0, 32'h0, 4'd0, 0, 1, 0);

    // Sticky error on read-while-empty, surviving drop_i.
    do_reset();
    cycle("err.rd_empty", 0, 32'h0, 4'd0, 0, 1, 0);
`ifdef FIFO_UNPACK_ERR_CHK_EN
    chk("err.set", bus.err_o, 1);
    cycle("err.drop", 0, 32'h0, 4'd0, 0, 0, 1);
    chk("err.sticky", bus.err_o, 1);
`else
    chk("err.off", bus.err_o, 0);
    cycle("err.drop", 0, 32'h0, 4'd0, 0, 0, 1);
    chk("err.off_drop", bus.err_o, 0);
`endif

    // Random traffic, illegal ops included, against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd", ($urandom_range(0, 99) < 55), $urandom, 4'($urandom_range(0, 8)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 2));
    end
    model_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
